// File: rtl/squeezer_h_if.sv
// Handshake bundle between squeezer_h, the permutation core and the output consumer.
// master = squeezer side; slave = permutation/consumer side.
interface squeezer_h_if #(
   parameter int RATE_WORDS = 9
);
   logic [64*RATE_WORDS-1:0] in;
   logic                     in_ready;
   logic                     in_ack;
   logic                     f_req;
   logic [63:0]              out;
   logic                     out_valid;
   logic                     out_ready;
   logic                     is_last;
   logic [2:0]               byte_num;
   logic                     done;

   modport master (
      input  in, in_ready, out_ready,
      output in_ack, f_req, out, out_valid, is_last, byte_num, done
   );

   modport slave (
      output in, in_ready, out_ready,
      input  in_ack, f_req, out, out_valid, is_last, byte_num, done
   );
endinterface

// File: rtl/squeezer_h.sv
// SHA-3 output serializer: captures rate blocks and streams them as 64-bit words.
// Define SQUEEZER_H_XOF_EN to enable multi-block (XOF) squeezing via f_req.
module squeezer_h #(
   parameter int OUT_BYTES  = 64,
   parameter int RATE_WORDS = 9
) (
   input  logic          clk,
   input  logic          reset,
   squeezer_h_if.master  bus
);
   localparam int         W           = 64 * RATE_WORDS;
   localparam int         TOTAL_WORDS = (OUT_BYTES + 7) / 8;
   localparam logic [9:0] LEFT_INIT   = 10'(TOTAL_WORDS);
   localparam logic [3:0] WCNT_LAST   = 4'(RATE_WORDS - 1);
   localparam logic [2:0] LAST_BYTES  = 3'(OUT_BYTES % 8);

   if (OUT_BYTES < 1 || OUT_BYTES > 1023) begin : g_bad_out_bytes
      $error("squeezer_h: OUT_BYTES must be in 1..1023");
   end
   if (RATE_WORDS < 1 || RATE_WORDS > 16) begin : g_bad_rate_words
      $error("squeezer_h: RATE_WORDS must fit the 4-bit word counter");
   end
`ifndef SQUEEZER_H_XOF_EN
   if (OUT_BYTES > RATE_WORDS * 8) begin : g_needs_xof
      $error("squeezer_h: OUT_BYTES exceeds one rate block without SQUEEZER_H_XOF_EN");
   end
`endif

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   sreg;
   logic [3:0]     wcnt;
   logic [9:0]     left;
   logic           capture;
   logic           emit;
   logic           xfer;
   logic           last_word;

   assign emit      = (state == S_EMIT);
   assign xfer      = emit & bus.out_ready;
   assign last_word = emit & (left == 10'd1);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

`ifdef SQUEEZER_H_XOF_EN
   logic blk_end;
   logic f_req_q;
`endif

   // NOTE: every signal written here gets its default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
`ifdef SQUEEZER_H_XOF_EN
      blk_end   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (bus.in_ready) begin
               capture   = 1'b1;
               state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               if (left == 10'd1) begin
                  state_nxt = S_DONE;
               end else if (wcnt == WCNT_LAST) begin
`ifdef SQUEEZER_H_XOF_EN
                  blk_end   = 1'b1;
                  state_nxt = S_WAIT;
`else
                  state_nxt = S_DONE;
`endif
               end
            end
         end
`ifdef SQUEEZER_H_XOF_EN
         S_WAIT: begin
            if (bus.in_ready) begin
               capture   = 1'b1;
               state_nxt = S_EMIT;
            end
         end
`endif
         default: ;
      endcase
   end

   // NOTE: sreg is a plain register, not a memory, so it is cleared by reset like the rest of the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg <= '0;
         wcnt <= '0;
         left <= LEFT_INIT;
      end else if (capture) begin
         sreg <= bus.in;
         wcnt <= '0;
      end else if (xfer) begin
         sreg <= {sreg[W-65:0], 64'b0};
         wcnt <= (wcnt == WCNT_LAST) ? 4'd0 : wcnt + 4'd1;
         left <= left - 10'd1;
      end
   end

`ifdef SQUEEZER_H_XOF_EN
   always_ff @(posedge clk) begin
      if (reset) f_req_q <= 1'b0;
      else       f_req_q <= blk_end;
   end
   assign bus.f_req = f_req_q;
`else
   assign bus.f_req = 1'b0;
`endif

   assign bus.in_ack    = capture;
   assign bus.out_valid = emit;
   assign bus.out       = emit ? sreg[W-1 -: 64] : 64'd0;
   assign bus.is_last   = last_word;
   assign bus.byte_num  = last_word ? LAST_BYTES : 3'd0;
   assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_squeezer_h.sv
// Self-checking bench for squeezer_h: several instances (64 B, 28 B, and 100 B when XOF is on)
// share one stimulus stream and are each compared against a queue-based reference model.
module tb_squeezer_h;
   localparam int RW = 9;
`ifdef SQUEEZER_H_XOF_EN
   localparam int ND  = 3;
   localparam bit XOF = 1'b1;
`else
   localparam int ND  = 2;
   localparam bit XOF = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [575:0] tb_in;
   logic         tb_in_ready;
   logic         tb_out_ready;

   always #5 clk = ~clk;

   squeezer_h_if #(.RATE_WORDS(RW)) bus_a ();
   squeezer_h_if #(.RATE_WORDS(RW)) bus_b ();
   assign bus_a.in = tb_in;  assign bus_a.in_ready = tb_in_ready;  assign bus_a.out_ready = tb_out_ready;
   assign bus_b.in = tb_in;  assign bus_b.in_ready = tb_in_ready;  assign bus_b.out_ready = tb_out_ready;

   squeezer_h #(.OUT_BYTES(64), .RATE_WORDS(RW)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   squeezer_h #(.OUT_BYTES(28), .RATE_WORDS(RW)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
`ifdef SQUEEZER_H_XOF_EN
   squeezer_h_if #(.RATE_WORDS(RW)) bus_c ();
   assign bus_c.in = tb_in;  assign bus_c.in_ready = tb_in_ready;  assign bus_c.out_ready = tb_out_ready;
   squeezer_h #(.OUT_BYTES(100), .RATE_WORDS(RW)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));
`endif

   typedef struct packed {
      logic        ov;
      logic [63:0] o;
      logic        il;
      logic [2:0]  bn;
      logic        ia;
      logic        fr;
      logic        dn;
   } obs_t;

   function automatic int ob_of(int d);
      case (d)
         0:       return 64;
         1:       return 28;
         default: return 100;
      endcase
   endfunction

   function automatic int total_of(int d);
      return (ob_of(d) + 7) / 8;
   endfunction

   function automatic obs_t sample(int d);
      obs_t s;
      s = '0;
      case (d)
         0: s = '{bus_a.out_valid, bus_a.out, bus_a.is_last, bus_a.byte_num, bus_a.in_ack, bus_a.f_req, bus_a.done};
         1: s = '{bus_b.out_valid, bus_b.out, bus_b.is_last, bus_b.byte_num, bus_b.in_ack, bus_b.f_req, bus_b.done};
`ifdef SQUEEZER_H_XOF_EN
         2: s = '{bus_c.out_valid, bus_c.out, bus_c.is_last, bus_c.byte_num, bus_c.in_ack, bus_c.f_req, bus_c.done};
`endif
         default: ;
      endcase
      return s;
   endfunction

   // Reference model: words still to emit from the current block, words already delivered,
   // whether a new block may be accepted, and the expected f_req / done levels.
   logic [63:0] q [3][$];
   int          sent [3];
   bit          acc [3];
   bit          fr_e [3];
   bit          dn_e [3];
   bit          jr [3];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int d, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, got, exp);
      end
   endtask

   task automatic model_reset(input int d);
      q[d].delete();
      sent[d] = 0;
      acc[d]  = 1'b1;
      fr_e[d] = 1'b0;
      dn_e[d] = 1'b0;
      jr[d]   = 1'b1;
   endtask

   task automatic model_clock(input int d);
      bit ev;
      int n;
      if (reset) begin
         model_reset(d);
         return;
      end
      jr[d]   = 1'b0;
      ev      = q[d].size() > 0;
      fr_e[d] = 1'b0;
      if (acc[d] && tb_in_ready) begin
         n = total_of(d) - sent[d];
         if (n > RW) n = RW;
         for (int k = 0; k < n; k++) q[d].push_back(tb_in[575-64*k -: 64]);
         acc[d] = 1'b0;
      end else if (ev && tb_out_ready) begin
         void'(q[d].pop_front());
         sent[d]++;
         if (sent[d] == total_of(d)) begin
            dn_e[d] = 1'b1;
         end else if (q[d].size() == 0) begin
            if (XOF) begin
               fr_e[d] = 1'b1;
               acc[d]  = 1'b1;
            end else begin
               dn_e[d] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      obs_t s;
      bit   ev;
      bit   last;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         s    = sample(d);
         ev   = q[d].size() > 0;
         last = ev && (sent[d] == total_of(d) - 1);
         check("out_valid", d, 64'(s.ov), 64'(ev));
         if (ev) begin
            check("out", d, s.o, q[d][0]);
            check("byte_num", d, 64'(s.bn), last ? 64'(ob_of(d) % 8) : 64'd0);
         end
         if (jr[d]) begin
            check("reset_out", d, s.o, 64'd0);
            check("reset_byte_num", d, 64'(s.bn), 64'd0);
         end
         check("is_last", d, 64'(s.il), 64'(last));
         check("in_ack", d, 64'(s.ia), 64'(acc[d] && tb_in_ready));
         check("f_req", d, 64'(s.fr), 64'(fr_e[d]));
         check("done", d, 64'(s.dn), 64'(dn_e[d]));
      end
      @(posedge clk);
      for (int d = 0; d < ND; d++) model_clock(d);
      #1;
   endtask

   task automatic rand_block();
      for (int k = 0; k < RW; k++) tb_in[575-64*k -: 64] = {$urandom(), $urandom()};
   endtask

   initial begin
      tb_in        = '0;
      tb_in_ready  = 1'b0;
      tb_out_ready = 1'b0;
      reset        = 1'b1;
      repeat (2) @(posedge clk);
      for (int d = 0; d < ND; d++) model_reset(d);
      #1;
      step();
      reset = 1'b0;

      // Counting pattern, in_ready held high through EMIT and DONE.
      for (int k = 0; k < RW; k++) tb_in[575-64*k -: 64] = 64'(k + 1);
      tb_in_ready  = 1'b1;
      tb_out_ready = 1'b1;
      repeat (18) step();
      tb_in_ready  = 1'b0;

      // Backpressure 1,0,0,1 with a second block offered later.
      reset = 1'b1;  step();  reset = 1'b0;
      rand_block();
      tb_in_ready = 1'b1;  step();  tb_in_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tb_out_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      rand_block();
      tb_in_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tb_out_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      tb_in_ready = 1'b0;

      // Second block presented five cycles after the f_req pulse.
      reset = 1'b1;  step();  reset = 1'b0;
      rand_block();
      tb_out_ready = 1'b1;
      tb_in_ready  = 1'b1;  step();  tb_in_ready = 1'b0;
      repeat (14) step();
      rand_block();
      tb_in_ready  = 1'b1;  step();  tb_in_ready = 1'b0;
      repeat (8) step();

      // Reset while the third word is on the bus, then restart.
      reset = 1'b1;  step();  reset = 1'b0;
      rand_block();
      tb_in_ready = 1'b1;  step();  tb_in_ready = 1'b0;
      repeat (2) step();
      reset = 1'b1;  step();  reset = 1'b0;
      step();
      rand_block();
      tb_in_ready = 1'b1;  step();  tb_in_ready = 1'b0;
      repeat (12) step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 99) == 0);
         tb_in_ready  = ($urandom_range(0, 3) == 0);
         tb_out_ready = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0) rand_block();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
